// File: rtl/writeback_stage_if.sv
// Writeback-stage bundle: ALU/load result handshakes, load issue, decode hazard queries and RF write port.
// Forwarding signals exist only when WB_FORWARD_EN is defined.
interface writeback_stage_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned addr_width = 5
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [addr_width-1:0] alu_rd;
    logic [XLEN-1:0]       alu_result;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [addr_width-1:0] mem_rd;
    logic [XLEN-1:0]       mem_data;

    logic                  issue_valid;
    logic [addr_width-1:0] issue_rd;

    logic [addr_width-1:0] rs1_addr;
    logic [addr_width-1:0] rs2_addr;
    logic                  rs1_busy;
    logic                  rs2_busy;

    logic                  rf_we;
    logic [addr_width-1:0] rf_addr;
    logic [XLEN-1:0]       rf_data;

`ifdef WB_FORWARD_EN
    logic                  rs1_fwd_hit;
    logic                  rs2_fwd_hit;
    logic [XLEN-1:0]       rs1_fwd_data;
    logic [XLEN-1:0]       rs2_fwd_data;
`endif

    modport master (
        output alu_valid, alu_rd, alu_result,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        output issue_valid, issue_rd,
        output rs1_addr, rs2_addr,
        input  rs1_busy, rs2_busy,
        input  rf_we, rf_addr, rf_data
`ifdef WB_FORWARD_EN
        , input rs1_fwd_hit, rs2_fwd_hit, rs1_fwd_data, rs2_fwd_data
`endif
    );

    modport slave (
        input  alu_valid, alu_rd, alu_result,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        input  issue_valid, issue_rd,
        input  rs1_addr, rs2_addr,
        output rs1_busy, rs2_busy,
        output rf_we, rf_addr, rf_data
`ifdef WB_FORWARD_EN
        , output rs1_fwd_hit, rs2_fwd_hit, rs1_fwd_data, rs2_fwd_data
`endif
    );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: merges fixed-latency ALU results and FIFO-buffered load results onto the single
// register-file write port and tracks outstanding loads for RAW stalls. WB_FORWARD_EN adds write-port forwarding.
module writeback_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned addr_width = 5,
    parameter int unsigned LQ_DEPTH   = 2
) (
    input logic              clk,
    input logic              rst_n,
    writeback_stage_if.slave wb
);
    localparam int unsigned PW   = $clog2(LQ_DEPTH);
    localparam int unsigned NREG = 2 ** addr_width;
    localparam logic [PW:0] PTR_ONE = 1;

    typedef struct packed {
        logic [addr_width-1:0] rd;
        logic [XLEN-1:0]       data;
    } lq_entry_t;

    lq_entry_t             lq_mem [LQ_DEPTH];
    logic [PW:0]           wr_ptr;
    logic [PW:0]           rd_ptr;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  alu_take;
    lq_entry_t             head;
    lq_entry_t             sel;
    logic                  sel_valid;
    logic                  sel_is_load;
    logic                  sel_we;

    logic                  rf_we_q;
    logic [addr_width-1:0] rf_addr_q;
    logic [XLEN-1:0]       rf_data_q;
    logic                  rf_from_load;

    logic [NREG-1:1]       sb;
    logic [NREG-1:1]       sb_next;
    logic [NREG-1:0]       sb_vec;

    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    end

    assign head     = lq_mem[rd_ptr[PW-1:0]];
    assign alu_take = wb.alu_valid && !fifo_full;
    // A full FIFO always drains, otherwise the head only goes when the ALU is idle.
    assign pop      = !fifo_empty && (!wb.alu_valid || fifo_full);
    assign push     = wb.mem_valid && !fifo_full;

    assign wb.alu_ready = !fifo_full;
    assign wb.mem_ready = !fifo_full;

    always_comb begin
        sel         = head;
        sel_valid   = 1'b0;
        sel_is_load = 1'b0;
        if (alu_take) begin
            sel.rd    = wb.alu_rd;
            sel.data  = wb.alu_result;
            sel_valid = 1'b1;
        end else if (pop) begin
            sel_valid   = 1'b1;
            sel_is_load = 1'b1;
        end
        sel_we = sel_valid && (sel.rd != '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            lq_mem[wr_ptr[PW-1:0]] <= '{rd: wb.mem_rd, data: wb.mem_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q      <= 1'b0;
            rf_addr_q    <= '0;
            rf_data_q    <= '0;
            rf_from_load <= 1'b0;
        end else begin
            rf_we_q      <= sel_we;
            rf_from_load <= sel_is_load;
            if (sel_we) begin
                rf_addr_q <= sel.rd;
                rf_data_q <= sel.data;
            end
        end
    end

    // Clear is applied first so a same-cycle issue to that register keeps it pending.
    always_comb begin
        sb_next = sb;
        for (int unsigned r = 1; r < NREG; r++) begin
            if (rf_we_q && rf_from_load && (rf_addr_q == addr_width'(r))) sb_next[r] = 1'b0;
            if (wb.issue_valid && (wb.issue_rd == addr_width'(r)))        sb_next[r] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sb <= '0;
        else        sb <= sb_next;
    end

    assign sb_vec = {sb, 1'b0};

    assign wb.rf_we   = rf_we_q;
    assign wb.rf_addr = rf_addr_q;
    assign wb.rf_data = rf_data_q;

`ifdef WB_FORWARD_EN
    logic fwd1;
    logic fwd2;
    assign fwd1 = rf_we_q && (rf_addr_q == wb.rs1_addr) && (wb.rs1_addr != '0);
    assign fwd2 = rf_we_q && (rf_addr_q == wb.rs2_addr) && (wb.rs2_addr != '0);
    assign wb.rs1_fwd_hit  = fwd1;
    assign wb.rs2_fwd_hit  = fwd2;
    assign wb.rs1_fwd_data = rf_data_q;
    assign wb.rs2_fwd_data = rf_data_q;
    assign wb.rs1_busy     = sb_vec[wb.rs1_addr] && !fwd1;
    assign wb.rs2_busy     = sb_vec[wb.rs2_addr] && !fwd2;
`else
    assign wb.rs1_busy = sb_vec[wb.rs1_addr];
    assign wb.rs2_busy = sb_vec[wb.rs2_addr];
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based model.
module tb_writeback_stage;
    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int NREG  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    writeback_stage_if #(.XLEN(XLEN), .addr_width(AW)) bus ();

    writeback_stage #(.XLEN(XLEN), .addr_width(AW), .LQ_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            lq[$];
    bit              pend[NREG];
    bit              e_we        = 1'b0;
    bit              e_from_load = 1'b0;
    logic [AW-1:0]   e_addr      = '0;
    logic [XLEN-1:0] e_data      = '0;

    task automatic model_reset();
        lq.delete();
        for (int i = 0; i < NREG; i++) pend[i] = 1'b0;
        e_we        = 1'b0;
        e_from_load = 1'b0;
    endtask

    function automatic bit fwd_hit(input logic [AW-1:0] a);
        return e_we && (e_addr == a) && (a != '0);
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
`ifdef WB_FORWARD_EN
        return pend[a] && !fwd_hit(a);
`else
        return pend[a];
`endif
    endfunction

    task automatic model_step();
        bit              full;
        bit              n_we;
        bit              n_fl;
        logic [AW-1:0]   n_addr;
        logic [XLEN-1:0] n_data;
        ent_t            h;
        full   = (lq.size() == DEPTH);
        n_we   = 1'b0;
        n_fl   = 1'b0;
        n_addr = e_addr;
        n_data = e_data;
        if (bus.alu_valid && !full) begin
            n_we   = (bus.alu_rd != '0);
            n_addr = bus.alu_rd;
            n_data = bus.alu_result;
        end else if (lq.size() > 0) begin
            h      = lq.pop_front();
            n_we   = (h.rd != '0);
            n_fl   = 1'b1;
            n_addr = h.rd;
            n_data = h.data;
        end
        if (bus.mem_valid && !full) begin
            h.rd   = bus.mem_rd;
            h.data = bus.mem_data;
            lq.push_back(h);
        end
        if (bus.issue_valid && bus.issue_rd != '0)
            assert (!pend[bus.issue_rd]) else $error("load issued to busy register %0d", bus.issue_rd);
        if (e_we && e_from_load) pend[e_addr] = 1'b0;
        if (bus.issue_valid && bus.issue_rd != '0) pend[bus.issue_rd] = 1'b1;
        if (n_we) begin
            e_addr = n_addr;
            e_data = n_data;
        end
        e_we        = n_we;
        e_from_load = n_fl && n_we;
    endtask

    task automatic compare();
        bit full;
        full = (lq.size() == DEPTH);
        chk("alu_ready", 32'(bus.alu_ready), 32'(!full));
        chk("mem_ready", 32'(bus.mem_ready), 32'(!full));
        chk("rf_we",     32'(bus.rf_we),     32'(e_we));
        if (e_we) begin
            chk("rf_addr", 32'(bus.rf_addr), 32'(e_addr));
            chk("rf_data", bus.rf_data,      e_data);
        end
        chk("rs1_busy", 32'(bus.rs1_busy), 32'(exp_busy(bus.rs1_addr)));
        chk("rs2_busy", 32'(bus.rs2_busy), 32'(exp_busy(bus.rs2_addr)));
`ifdef WB_FORWARD_EN
        chk("rs1_fwd_hit", 32'(bus.rs1_fwd_hit), 32'(fwd_hit(bus.rs1_addr)));
        chk("rs2_fwd_hit", 32'(bus.rs2_fwd_hit), 32'(fwd_hit(bus.rs2_addr)));
        if (fwd_hit(bus.rs1_addr)) chk("rs1_fwd_data", bus.rs1_fwd_data, e_data);
        if (fwd_hit(bus.rs2_addr)) chk("rs2_fwd_data", bus.rs2_fwd_data, e_data);
`endif
    endtask

    // Single compare process: inputs change on negedge, outputs checked 2 units later.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) model_reset();
            compare();
            @(posedge clk);
            if (rst_n) model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_result  = '0;
        bus.mem_valid   = 1'b0;
        bus.mem_rd      = '0;
        bus.mem_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.rs1_addr    = '0;
        bus.rs2_addr    = '0;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        @(negedge clk);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = rd;
        @(negedge clk);
        bus.issue_valid = 1'b0;
    endtask

    bit          alu_acc = 1'b0;
    bit          mem_acc = 1'b0;
    int unsigned outst[$];

    initial begin
        idle_inputs();
        bus.rs1_addr = 5'd5;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        chk("reset_rf_we",     32'(bus.rf_we),     32'd0);
        chk("reset_rf_addr",   32'(bus.rf_addr),   32'd0);
        chk("reset_rf_data",   bus.rf_data,        32'd0);
        chk("reset_alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("reset_mem_ready", 32'(bus.mem_ready), 32'd1);
        chk("reset_rs1_busy",  32'(bus.rs1_busy),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU only
        @(negedge clk);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_result = 32'hDEADBEEF;
        @(negedge clk);
        bus.alu_valid = 1'b0;
        #3;
        chk("alu_we",   32'(bus.rf_we),   32'd1);
        chk("alu_addr", 32'(bus.rf_addr), 32'd5);
        chk("alu_data", bus.rf_data,      32'hDEADBEEF);

        // x0 destination is accepted but not written
        @(negedge clk);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_result = 32'h1234;
        #3;
        chk("x0_alu_ready", 32'(bus.alu_ready), 32'd1);
        @(negedge clk);
        bus.alu_valid = 1'b0;
        #3;
        chk("x0_rf_we", 32'(bus.rf_we), 32'd0);

        // Priority: ALU rd=3 beats queued load rd=7
        issue(5'd7);
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h55;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_result = 32'h33;
        bus.rs1_addr  = 5'd7;
        #3;
        chk("prio_busy7", 32'(bus.rs1_busy), 32'd1);
        @(negedge clk);
        bus.alu_valid = 1'b0;
        #3;
        chk("prio_first_we",   32'(bus.rf_we),   32'd1);
        chk("prio_first_addr", 32'(bus.rf_addr), 32'd3);
        @(negedge clk);
        #3;
        chk("prio_second_addr", 32'(bus.rf_addr), 32'd7);
        chk("prio_second_data", bus.rf_data,      32'h55);
        @(negedge clk);
        #3;
        chk("prio_busy7_cleared", 32'(bus.rs1_busy), 32'd0);

        // Scoreboard on rd=10
        @(negedge clk);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd10; bus.rs1_addr = 5'd10;
        #3;
        chk("sb_busy_issue_cycle", 32'(bus.rs1_busy), 32'd0);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        #3;
        chk("sb_busy_set", 32'(bus.rs1_busy), 32'd1);
        @(negedge clk);
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd10; bus.mem_data = 32'hA5A5A5A5;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        #3;
        chk("sb_busy_queued", 32'(bus.rs1_busy), 32'd1);
        @(negedge clk);
        #3;
        chk("sb_write_addr", 32'(bus.rf_addr), 32'd10);
        chk("sb_write_data", bus.rf_data,      32'hA5A5A5A5);
`ifdef WB_FORWARD_EN
        chk("sb_busy_write_cycle", 32'(bus.rs1_busy),    32'd0);
        chk("sb_fwd_hit",          32'(bus.rs1_fwd_hit), 32'd1);
        chk("sb_fwd_data",         bus.rs1_fwd_data,     32'hA5A5A5A5);
`else
        chk("sb_busy_write_cycle", 32'(bus.rs1_busy), 32'd1);
`endif
        @(negedge clk);
        #3;
        chk("sb_busy_after", 32'(bus.rs1_busy), 32'd0);

        // Full FIFO under constant alu_valid
        issue(5'd8);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_result = 32'hC;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd8;  bus.mem_data   = 32'h88;
        #3;
        chk("full_mem_ready_c1", 32'(bus.mem_ready), 32'd1);
        @(negedge clk);
        bus.mem_rd = 5'd9; bus.mem_data = 32'h99;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        #3;
        chk("full_mem_ready", 32'(bus.mem_ready), 32'd0);
        chk("full_alu_ready", 32'(bus.alu_ready), 32'd0);
        @(negedge clk);
        #3;
        chk("full_first_addr", 32'(bus.rf_addr),   32'd8);
        chk("full_first_data", bus.rf_data,        32'h88);
        chk("full_alu_back",   32'(bus.alu_ready), 32'd1);
        @(negedge clk);
        bus.alu_valid = 1'b0;
        #3;
        chk("full_alu_addr", 32'(bus.rf_addr), 32'd12);
        @(negedge clk);
        #3;
        chk("full_second_addr", 32'(bus.rf_addr), 32'd9);
        chk("full_second_data", bus.rf_data,      32'h99);

        // Reset mid-stream with two loads queued
        issue(5'd20);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd21;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1;  bus.alu_result = 32'h1;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd20; bus.mem_data   = 32'h2020;
        @(negedge clk);
        bus.mem_rd = 5'd21; bus.mem_data = 32'h2121;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        #3;
        chk("rst_two_queued", 32'(bus.mem_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        #3;
        chk("rst_mid_rf_we",     32'(bus.rf_we),     32'd0);
        chk("rst_mid_mem_ready", 32'(bus.mem_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            @(negedge clk);
            bus.rs1_addr = AW'(i);
            #3;
            chk("rst_post_busy",  32'(bus.rs1_busy),  32'd0);
            chk("rst_post_rf_we", 32'(bus.rf_we),     32'd0);
            chk("rst_post_ready", 32'(bus.mem_ready), 32'd1);
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int unsigned rdc;
            @(negedge clk);
            if (!bus.alu_valid || alu_acc) begin
                bus.alu_valid  = ($urandom_range(0, 2) != 0);
                bus.alu_rd     = AW'($urandom_range(0, NREG - 1));
                bus.alu_result = $urandom();
            end
            if (!bus.mem_valid || mem_acc) begin
                if (outst.size() > 0 && $urandom_range(0, 1) == 1) begin
                    bus.mem_valid = 1'b1;
                    bus.mem_rd    = AW'(outst.pop_front());
                    bus.mem_data  = $urandom();
                end else begin
                    bus.mem_valid = 1'b0;
                end
            end
            rdc = $urandom_range(1, NREG - 1);
            if ($urandom_range(0, 2) == 0 && !pend[rdc]) begin
                bus.issue_valid = 1'b1;
                bus.issue_rd    = AW'(rdc);
                outst.push_back(rdc);
            end else begin
                bus.issue_valid = 1'b0;
            end
            bus.rs1_addr = AW'($urandom_range(0, NREG - 1));
            bus.rs2_addr = AW'($urandom_range(0, NREG - 1));
            #1;
            alu_acc = bus.alu_valid && bus.alu_ready;
            mem_acc = bus.mem_valid && bus.mem_ready;
        end

        @(negedge clk);
        idle_inputs();
        repeat (10) @(negedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
